// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial shifter with valid/ready word input and idle-level gap.
// Optional BIT_SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        gap_q, gap_d;
  logic              sout_q, sout_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      sout_q   <= IDLE_BIT;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sout_q   <= sout_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // The head of word_q is the bit presented next; serial_out is the registered copy.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sout_d   = IDLE_BIT;
    done     = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          word_d  = data_in;
          cnt_d   = CNT_LOAD;
          sout_d  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
          state_d = S_SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          word_d = MSB_FIRST ? (word_q << 1) : (word_q >> 1);
          sout_d = MSB_FIRST ? word_q[WIDTH-2] : word_q[1];
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          sout_d  = parity_q;
          state_d = S_PARITY;
`else
          done = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_PARITY: begin
        done = 1'b1;
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_ready = (state_q == S_IDLE) && !rst;
  assign serial_out = sout_q;
  assign busy       = (state_q != S_IDLE);

endmodule
